dnn_cmd_ctrl: RTL and testbench

//  Responder for the 3-bit fsm_input command interface that drives dnn_hw_top (DEFAULT, LD_WT_SRAM2PE,
//  LD_IF_SRAM2BUF, LD_IF_BUF2PE, DNNEXEC, UNLD_OF_PE2BUF, UNLD_OF_BUF2SRAM). Samples one command when idle,

---
 rtl/dnn_cmd_ctrl_if.sv | 46 ++++
 rtl/dnn_cmd_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dnn_cmd_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dnn_cmd_ctrl_if.sv
// Command/strobe bundle between the dnn_hw_top command port and dnn_cmd_ctrl.
// Optional perf counters appear when CMD_CTRL_PERF_EN is defined.
interface dnn_cmd_ctrl_if #(
    parameter int unsigned X_DIM = 4
);
    localparam int unsigned CW = $clog2(X_DIM + 1);

    logic          start;
    logic [2:0]    fsm_input;
    logic          busy;
    logic          op_done;
    logic          cmd_err;
    logic [2:0]    cur_cmd;
    logic          acc_clr;
    logic          wt_ld;
    logic          if_wr;
    logic [CW-1:0] if_wr_col;
    logic          if_shift;
    logic [CW-1:0] if_rd_col;
    logic          mac_en;
    logic          of_shift;
    logic          of_wr;
    logic [CW-1:0] of_col;
`ifdef CMD_CTRL_PERF_EN
    logic [31:0]   perf_busy_cyc;
    logic [31:0]   perf_mac_cyc;
`endif

    modport master (
        output start, fsm_input,
        input  busy, op_done, cmd_err, cur_cmd, acc_clr, wt_ld, if_wr, if_wr_col,
               if_shift, if_rd_col, mac_en, of_shift, of_wr, of_col
`ifdef CMD_CTRL_PERF_EN
               , perf_busy_cyc, perf_mac_cyc
`endif
    );

    modport slave (
        input  start, fsm_input,
        output busy, op_done, cmd_err, cur_cmd, acc_clr, wt_ld, if_wr, if_wr_col,
               if_shift, if_rd_col, mac_en, of_shift, of_wr, of_col
`ifdef CMD_CTRL_PERF_EN
               , perf_busy_cyc, perf_mac_cyc
`endif
    );
endinterface

// File: rtl/dnn_cmd_ctrl.sv
// Command sequencer for dnn_hw_top: samples a 3-bit command in IDLE, runs it for a fixed
// cycle count, drives the PE/FIFO strobes and tracks buffer columns. Option: CMD_CTRL_PERF_EN.
module dnn_cmd_ctrl #(
    parameter int unsigned X_DIM     = 4,
    parameter int unsigned WT_CYC    = 1,
    parameter int unsigned IF_WR_CYC = 1,
    parameter int unsigned IF_SH_CYC = 2,
    parameter int unsigned EXEC_CYC  = 26,
    parameter int unsigned OF_SH_CYC = 2,
    parameter int unsigned OF_WR_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    dnn_cmd_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(X_DIM + 1);

    localparam logic [2:0] CMD_NONE    = 3'b000;
    localparam logic [2:0] CMD_DEFAULT = 3'b001;
    localparam logic [2:0] CMD_LD_WT   = 3'b010;
    localparam logic [2:0] CMD_IF_WR   = 3'b011;
    localparam logic [2:0] CMD_IF_SH   = 3'b100;
    localparam logic [2:0] CMD_EXEC    = 3'b101;
    localparam logic [2:0] CMD_OF_SH   = 3'b110;
    localparam logic [2:0] CMD_OF_WR   = 3'b111;

    // Strobe vector bit positions
    localparam int unsigned S_WT   = 0;
    localparam int unsigned S_IFWR = 1;
    localparam int unsigned S_IFSH = 2;
    localparam int unsigned S_MAC  = 3;
    localparam int unsigned S_OFSH = 4;
    localparam int unsigned S_OFWR = 5;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(WT_CYC, IF_WR_CYC), max2(IF_SH_CYC, EXEC_CYC)),
                                           max2(OF_SH_CYC, OF_WR_CYC));
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       cur_cmd;
    logic             busy;
    logic             op_done;
    logic             cmd_err;
    logic             acc_clr;
    logic [5:0]       strb;
    logic [CW-1:0]    if_wr_col;
    logic [CW-1:0]    if_rd_col;
    logic [CW-1:0]    of_col;

    // Remaining-cycle preload (N-1) for each command
    function automatic logic [CNT_W-1:0] cyc_for(input logic [2:0] cmd);
        case (cmd)
            CMD_LD_WT: return CNT_W'(WT_CYC - 1);
            CMD_IF_WR: return CNT_W'(IF_WR_CYC - 1);
            CMD_IF_SH: return CNT_W'(IF_SH_CYC - 1);
            CMD_EXEC:  return CNT_W'(EXEC_CYC - 1);
            CMD_OF_SH: return CNT_W'(OF_SH_CYC - 1);
            CMD_OF_WR: return CNT_W'(OF_WR_CYC - 1);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [5:0] strobe_for(input logic [2:0] cmd);
        logic [5:0] s;
        s = '0;
        case (cmd)
            CMD_LD_WT: s[S_WT]   = 1'b1;
            CMD_IF_WR: s[S_IFWR] = 1'b1;
            CMD_IF_SH: s[S_IFSH] = 1'b1;
            CMD_EXEC:  s[S_MAC]  = 1'b1;
            CMD_OF_SH: s[S_OFSH] = 1'b1;
            CMD_OF_WR: s[S_OFWR] = 1'b1;
            default:   s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [CW-1:0] col_next(input logic [CW-1:0] c);
        return (c == CW'(X_DIM)) ? '0 : c + CW'(1);
    endfunction

    // Sequencer: IDLE samples one command, RUN holds its strobe until cyc_cnt hits 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            cur_cmd   <= CMD_DEFAULT;
            busy      <= 1'b0;
            op_done   <= 1'b0;
            cmd_err   <= 1'b0;
            acc_clr   <= 1'b0;
            strb      <= '0;
            if_wr_col <= '0;
            if_rd_col <= '0;
            of_col    <= '0;
        end else begin
            op_done <= 1'b0;
            cmd_err <= 1'b0;
            acc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_clr   <= 1'b1;
                        if_wr_col <= '0;
                        if_rd_col <= '0;
                        of_col    <= '0;
                    end else if (bus.fsm_input == CMD_NONE) begin
                        cmd_err <= 1'b1;
                    end else if (bus.fsm_input != CMD_DEFAULT) begin
                        state   <= RUN;
                        cur_cmd <= bus.fsm_input;
                        cyc_cnt <= cyc_for(bus.fsm_input);
                        strb    <= strobe_for(bus.fsm_input);
                        busy    <= 1'b1;
                        op_done <= (cyc_for(bus.fsm_input) == '0);
                    end
                end
                RUN: begin
                    if (bus.start) begin
                        cmd_err <= 1'b1;
                    end
                    if (cyc_cnt == '0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        strb    <= '0;
                        cur_cmd <= CMD_DEFAULT;
                        // Write-back to SRAM drains the OF buffer in place; only PE2BUF steps of_col
                        case (cur_cmd)
                            CMD_IF_WR: if_wr_col <= col_next(if_wr_col);
                            CMD_IF_SH: if_rd_col <= col_next(if_rd_col);
                            CMD_EXEC:  if_rd_col <= '0;
                            CMD_OF_SH: of_col    <= col_next(of_col);
                            default:   ;
                        endcase
                    end else begin
                        cyc_cnt <= cyc_cnt - CNT_W'(1);
                        op_done <= (cyc_cnt == CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMD_CTRL_PERF_EN
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_mac_cyc;

    // Saturating activity counters, cleared with the layer
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && bus.start)) begin
            perf_busy_cyc <= '0;
            perf_mac_cyc  <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if (strb[S_MAC] && perf_mac_cyc != '1) begin
                perf_mac_cyc <= perf_mac_cyc + 32'd1;
            end
        end
    end

    assign bus.perf_busy_cyc = perf_busy_cyc;
    assign bus.perf_mac_cyc  = perf_mac_cyc;
`endif

    assign bus.busy      = busy;
    assign bus.op_done   = op_done;
    assign bus.cmd_err   = cmd_err;
    assign bus.cur_cmd   = cur_cmd;
    assign bus.acc_clr   = acc_clr;
    assign bus.wt_ld     = strb[S_WT];
    assign bus.if_wr     = strb[S_IFWR];
    assign bus.if_shift  = strb[S_IFSH];
    assign bus.mac_en    = strb[S_MAC];
    assign bus.of_shift  = strb[S_OFSH];
    assign bus.of_wr     = strb[S_OFWR];
    assign bus.if_wr_col = if_wr_col;
    assign bus.if_rd_col = if_rd_col;
    assign bus.of_col    = of_col;

endmodule

// File: tb/tb_dnn_cmd_ctrl.sv
// Bench for dnn_cmd_ctrl: directed scenarios plus random commands, checked every cycle
// against an operation-level model (remaining active cycles, column counters).
module tb_dnn_cmd_ctrl;
    localparam int unsigned X_DIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dnn_cmd_ctrl_if #(.X_DIM(X_DIM)) bus ();

    dnn_cmd_ctrl #(.X_DIM(X_DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model: m_left = active cycles still to come, including the current one
    int unsigned m_left = 0;
    int unsigned m_cmd  = 1;
    int unsigned m_err  = 0;
    int unsigned m_acc  = 0;
    int unsigned m_wcol = 0;
    int unsigned m_rcol = 0;
    int unsigned m_ocol = 0;
    int unsigned m_pbusy = 0;
    int unsigned m_pmac  = 0;

    int unsigned mac_cnt = 0;
    int unsigned err_cnt = 0;
    bit          collect_if = 1'b0;
    int unsigned if_cols[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int unsigned op_len(input int unsigned cmd);
        case (cmd)
            2: return 1;
            3: return 1;
            4: return 2;
            5: return 26;
            6: return 2;
            7: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_left = 0; m_cmd = 1; m_err = 0; m_acc = 0;
            m_wcol = 0; m_rcol = 0; m_ocol = 0; m_pbusy = 0; m_pmac = 0;
            return;
        end
        m_err = 0;
        m_acc = 0;
        if (m_left > 0) begin
            m_pbusy++;
            if (m_cmd == 5) m_pmac++;
            if (bus.start) m_err = 1;
            if (m_left == 1) begin
                case (m_cmd)
                    3: m_wcol = (m_wcol + 1) % (X_DIM + 1);
                    4: m_rcol = (m_rcol + 1) % (X_DIM + 1);
                    5: m_rcol = 0;
                    6: m_ocol = (m_ocol + 1) % (X_DIM + 1);
                    default: ;
                endcase
                m_cmd = 1;
            end
            m_left--;
        end else if (bus.start) begin
            m_acc = 1; m_wcol = 0; m_rcol = 0; m_ocol = 0; m_pbusy = 0; m_pmac = 0;
        end else if (bus.fsm_input == 3'b000) begin
            m_err = 1;
        end else if (bus.fsm_input != 3'b001) begin
            m_cmd  = 32'(bus.fsm_input);
            m_left = op_len(m_cmd);
        end
    endtask

    task automatic compare();
        logic [5:0]  strb;
        int unsigned exp_strb;
        strb = {bus.of_wr, bus.of_shift, bus.mac_en, bus.if_shift, bus.if_wr, bus.wt_ld};
        exp_strb = (m_left > 0) ? (32'd1 << (m_cmd - 2)) : 0;
        check_eq("busy",      32'(bus.busy),      32'(m_left > 0));
        check_eq("op_done",   32'(bus.op_done),   32'(m_left == 1));
        check_eq("cmd_err",   32'(bus.cmd_err),   m_err);
        check_eq("acc_clr",   32'(bus.acc_clr),   m_acc);
        check_eq("cur_cmd",   32'(bus.cur_cmd),   (m_left > 0) ? m_cmd : 1);
        check_eq("strobes",   32'(strb),          exp_strb);
        check_eq("if_wr_col", 32'(bus.if_wr_col), m_wcol);
        check_eq("if_rd_col", 32'(bus.if_rd_col), m_rcol);
        check_eq("of_col",    32'(bus.of_col),    m_ocol);
`ifdef CMD_CTRL_PERF_EN
        check_eq("perf_busy", bus.perf_busy_cyc,  m_pbusy);
        check_eq("perf_mac",  bus.perf_mac_cyc,   m_pmac);
`endif
        if (bus.mac_en) mac_cnt++;
        if (bus.cmd_err) err_cnt++;
        if (collect_if && bus.if_wr) if_cols.push_back(32'(bus.if_wr_col));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic drive(input logic r, input logic s, input logic [2:0] f, input int unsigned n);
        rst           = r;
        bus.start     = s;
        bus.fsm_input = f;
        for (int i = 0; i < int'(n); i++) begin
            tick();
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int unsigned hold;
        logic [2:0]  fi;
        bus.start     = 1'b0;
        bus.fsm_input = 3'b001;

        // Reset then idle
        drive(1'b1, 1'b0, 3'b001, 2);
        drive(1'b0, 1'b0, 3'b001, 2);

        // Single-cycle weight load
        drive(1'b0, 1'b0, 3'b010, 1);
        drive(1'b0, 1'b0, 3'b001, 3);

        // Back-to-back IF writes with column wrap
        collect_if = 1'b1;
        drive(1'b0, 1'b0, 3'b011, 12);
        drive(1'b0, 1'b0, 3'b001, 2);
        collect_if = 1'b0;
        check_eq("if_wr_pulses", if_cols.size(), 6);
        for (int i = 0; i < 6 && i < if_cols.size(); i++)
            check_eq("if_wr_seq", if_cols[i], (i == 5) ? 0 : i);

        // DNNEXEC with a BUF2PE presented mid-run
        mac_cnt = 0;
        drive(1'b0, 1'b0, 3'b101, 1);
        drive(1'b0, 1'b0, 3'b100, 5);
        drive(1'b0, 1'b0, 3'b001, 28);
        check_eq("exec_mac_cycles", mac_cnt, 26);

        // start during RUN, then start in IDLE after moving columns
        mac_cnt = 0;
        err_cnt = 0;
        drive(1'b0, 1'b0, 3'b101, 1);
        drive(1'b0, 1'b0, 3'b001, 9);
        drive(1'b0, 1'b1, 3'b001, 1);
        drive(1'b0, 1'b0, 3'b001, 20);
        check_eq("exec_mac_with_start", mac_cnt, 26);
        check_eq("start_busy_err", err_cnt, 1);
        drive(1'b0, 1'b0, 3'b100, 1);
        drive(1'b0, 1'b0, 3'b110, 1);
        drive(1'b0, 1'b0, 3'b011, 1);
        drive(1'b0, 1'b0, 3'b001, 3);
        drive(1'b0, 1'b1, 3'b101, 1);
        drive(1'b0, 1'b0, 3'b001, 2);

        // Illegal code, then reset in the middle of PE2BUF
        drive(1'b0, 1'b0, 3'b000, 1);
        drive(1'b0, 1'b0, 3'b001, 2);
        drive(1'b0, 1'b0, 3'b110, 4);
        drive(1'b1, 1'b0, 3'b110, 1);
        drive(1'b0, 1'b0, 3'b001, 3);

        // Random traffic
        hold = 0;
        fi   = 3'b001;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                fi   = ($urandom_range(15) == 0) ? 3'b000 : 3'($urandom_range(7, 1));
                hold = $urandom_range(6, 1);
            end
            hold--;
            drive(($urandom_range(99) == 0), ($urandom_range(19) == 0), fi, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
